div_result_buffer: RTL and testbench

- Downstream companion to the 64-bit, 10-stage pipelined signed divider.
- Captures every divider result (data_valid / quotient / div_by_zero) into a first-word-fall-through FIFO and presents it on a valid/ready interface.
- The divider has no backpressure, so this block also hands out issue credits upstream: a start is only launched when FIFO space is guaranteed for its result.

---
 rtl/div_result_buffer.sv | 104 ++++++++++
 tb/tb_div_result_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/div_result_buffer.sv
// Result FIFO and issue-credit tracker behind the pipelined signed divider.
// The divider cannot stall, so a start is only granted when a FIFO slot is reserved for its result.
module div_result_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_req,
  output logic             issue_ok,
  output logic             issue_grant,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic             div_dbz,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_quotient,
  output logic             res_dbz,
  output logic [CW-1:0]    credits,
  output logic             err_overflow,
  output logic             err_spurious
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef struct packed {
    logic             dbz;
    logic [WIDTH-1:0] quo;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [CW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   infl_q, infl_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_spur_q, err_spur_d;

  logic full, push, pop, retire;

  assign credits     = DEPTH_C - occ_q - infl_q;
  assign issue_ok    = (credits != '0);
  assign issue_grant = issue_req & issue_ok;

  assign res_valid = (occ_q != '0);
  assign pop       = res_valid & res_ready;
  assign full      = (occ_q == DEPTH_C);
  // When full, a same-cycle pop frees the head slot, which is exactly where wptr points.
  assign push      = div_valid & (~full | pop);
  assign retire    = div_valid & (infl_q != '0);

  always_comb begin
    occ_d      = occ_q;
    infl_d     = infl_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    err_ovf_d  = err_ovf_q | (div_valid & full & ~pop);
    err_spur_d = err_spur_q | (div_valid & (infl_q == '0));
    case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    case ({issue_grant, retire})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: infl_d = infl_q;
    endcase
    if (push) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
    if (pop)  rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q      <= '0;
      infl_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      err_ovf_q  <= 1'b0;
      err_spur_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      infl_q     <= infl_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      err_ovf_q  <= err_ovf_d;
      err_spur_q <= err_spur_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{dbz: div_dbz, quo: div_quotient};
  end

  assign res_quotient = res_valid ? mem_q[rptr_q].quo : '0;
  assign res_dbz      = res_valid ? mem_q[rptr_q].dbz : 1'b0;
  assign err_overflow = err_ovf_q;
  assign err_spurious = err_spur_q;

endmodule

// File: tb/tb_div_result_buffer.sv
// Directed bench for div_result_buffer; the divider is emulated by driving div_valid by hand.
module tb_div_result_buffer;

  localparam int WIDTH = 64;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_req;
  logic             issue_ok;
  logic             issue_grant;
  logic             div_valid;
  logic [WIDTH-1:0] div_quotient;
  logic             div_dbz;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_quotient;
  logic             res_dbz;
  logic [CW-1:0]    credits;
  logic             err_overflow;
  logic             err_spurious;

  int n_checks = 0;
  int n_fail   = 0;

  div_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_req(issue_req), .issue_ok(issue_ok), .issue_grant(issue_grant),
    .div_valid(div_valid), .div_quotient(div_quotient), .div_dbz(div_dbz),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_quotient(res_quotient), .res_dbz(res_dbz),
    .credits(credits), .err_overflow(err_overflow), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; issue_req = 1'b0; div_valid = 1'b0;
    div_quotient = '0; div_dbz = 1'b0; res_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (credits !== 5'd16) begin n_fail++; $display("FAIL reset_credits got %0d exp 16", credits); end
    n_checks++; if (issue_ok !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ok got %b exp 1", issue_ok); end
    n_checks++; if (issue_grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant got %b exp 0", issue_grant); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    n_checks++; if (res_quotient !== 64'h0) begin n_fail++; $display("FAIL reset_quotient got %h exp 0", res_quotient); end
    n_checks++; if (res_dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b exp 0", res_dbz); end
    n_checks++; if ({err_overflow, err_spurious} !== 2'b00) begin n_fail++; $display("FAIL reset_errors got %b exp 00", {err_overflow, err_spurious}); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] q [3];
    logic             d [3];
    q[0] = 64'h5; q[1] = 64'hFFFF_FFFF_FFFF_FFFD; q[2] = 64'h0;
    d[0] = 1'b0;  d[1] = 1'b0;                    d[2] = 1'b1;
    res_ready = 1'b1;
    issue_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (issue_grant !== 1'b1) begin n_fail++; $display("FAIL basic_grant%0d got %b exp 1", i, issue_grant); end
      tick();
    end
    issue_req = 1'b0;
    n_checks++; if (credits !== 5'd13) begin n_fail++; $display("FAIL basic_credits_inflight got %0d exp 13", credits); end
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 3; i++) begin
      div_valid = 1'b1; div_quotient = q[i]; div_dbz = d[i];
      n_checks++; if (res_valid !== (i != 0)) begin n_fail++; $display("FAIL basic_pre_valid%0d got %b exp %b", i, res_valid, (i != 0)); end
      tick();
      n_checks++; if (res_valid !== 1'b1 || res_quotient !== q[i] || res_dbz !== d[i]) begin
        n_fail++; $display("FAIL basic_head%0d got v=%b q=%h z=%b exp v=1 q=%h z=%b", i, res_valid, res_quotient, res_dbz, q[i], d[i]);
      end
    end
    div_valid = 1'b0; div_dbz = 1'b0;
    tick();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got %b exp 0", res_valid); end
    n_checks++; if (credits !== 5'd16) begin n_fail++; $display("FAIL basic_credits_back got %0d exp 16", credits); end
  endtask

  // Grants DEPTH issues then returns DEPTH results with quotient base+i; leaves the FIFO full.
  task automatic fill_fifo(input logic [WIDTH-1:0] base);
    res_ready = 1'b0;
    issue_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++; if (issue_grant !== 1'b1) begin n_fail++; $display("FAIL fill_grant%0d got %b exp 1", i, issue_grant); end
      tick();
    end
    n_checks++; if (issue_ok !== 1'b0 || credits !== 5'd0) begin n_fail++; $display("FAIL fill_no_credit got ok=%b c=%0d exp ok=0 c=0", issue_ok, credits); end
    n_checks++; if (issue_grant !== 1'b0) begin n_fail++; $display("FAIL fill_req_ignored got %b exp 0", issue_grant); end
    tick();
    issue_req = 1'b0;
    n_checks++; if (credits !== 5'd0) begin n_fail++; $display("FAIL fill_credits_hold got %0d exp 0", credits); end
    for (int i = 0; i < DEPTH; i++) begin
      div_valid = 1'b1; div_quotient = base + WIDTH'(i);
      tick();
    end
    div_valid = 1'b0;
    n_checks++; if (res_valid !== 1'b1 || res_quotient !== base) begin n_fail++; $display("FAIL fill_head got v=%b q=%h exp v=1 q=%h", res_valid, res_quotient, base); end
    n_checks++; if (credits !== 5'd0) begin n_fail++; $display("FAIL fill_full_credits got %0d exp 0", credits); end
  endtask

  task automatic test_full();
    fill_fifo(64'd100);
    res_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (res_quotient !== 64'd100 + 64'(i)) begin n_fail++; $display("FAIL full_pop%0d got %0d exp %0d", i, res_quotient, 100 + i); end
      tick();
      n_checks++; if (credits !== 5'(i + 1)) begin n_fail++; $display("FAIL full_credit%0d got %0d exp %0d", i, credits, i + 1); end
    end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty got %b exp 0", res_valid); end
    n_checks++; if ({err_overflow, err_spurious} !== 2'b00) begin n_fail++; $display("FAIL full_errors got %b exp 00", {err_overflow, err_spurious}); end
  endtask

  task automatic test_overflow();
    fill_fifo(64'd200);
    // Push and pop together while full: accepted, occupancy unchanged.
    res_ready = 1'b1; div_valid = 1'b1; div_quotient = 64'hAA;
    tick();
    div_valid = 1'b0; res_ready = 1'b0;
    n_checks++; if (credits !== 5'd0 || res_quotient !== 64'd201) begin n_fail++; $display("FAIL ovf_pushpop got c=%0d q=%0d exp c=0 q=201", credits, res_quotient); end
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pushpop_err got %b exp 0", err_overflow); end
    // Pop blocked: the result is dropped.
    div_valid = 1'b1; div_quotient = 64'hBB;
    tick();
    div_valid = 1'b0;
    n_checks++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", err_overflow); end
    tick(); tick();
    n_checks++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", err_overflow); end
    res_ready = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) tick();
    n_checks++; if (res_valid !== 1'b1 || res_quotient !== 64'hAA) begin n_fail++; $display("FAIL ovf_last got v=%b q=%h exp v=1 q=aa", res_valid, res_quotient); end
    tick();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped got %b exp 0", res_valid); end
  endtask

  task automatic test_spurious();
    do_reset();
    div_valid = 1'b1; div_quotient = 64'h77; div_dbz = 1'b1;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL spur_no_bypass got %b exp 0", res_valid); end
    tick();
    div_valid = 1'b0; div_dbz = 1'b0;
    n_checks++; if (res_valid !== 1'b1 || res_quotient !== 64'h77 || res_dbz !== 1'b1) begin n_fail++; $display("FAIL spur_queued got v=%b q=%h z=%b exp v=1 q=77 z=1", res_valid, res_quotient, res_dbz); end
    n_checks++; if (err_spurious !== 1'b1 || err_overflow !== 1'b0) begin n_fail++; $display("FAIL spur_flags got s=%b o=%b exp s=1 o=0", err_spurious, err_overflow); end
    n_checks++; if (credits !== 5'd15) begin n_fail++; $display("FAIL spur_credits got %0d exp 15", credits); end
  endtask

  // Follows test_spurious: one entry already queued and err_spurious set.
  task automatic test_reset_mid();
    res_ready = 1'b0;
    issue_req = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    issue_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      div_valid = 1'b1; div_quotient = 64'(i);
      tick();
    end
    div_valid = 1'b0;
    n_checks++; if (credits !== 5'd7) begin n_fail++; $display("FAIL mid_credits got %0d exp 7", credits); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (res_valid !== 1'b0 || res_quotient !== 64'h0) begin n_fail++; $display("FAIL mid_res got v=%b q=%h exp v=0 q=0", res_valid, res_quotient); end
    n_checks++; if (credits !== 5'd16 || issue_ok !== 1'b1) begin n_fail++; $display("FAIL mid_credits_rst got c=%0d ok=%b exp c=16 ok=1", credits, issue_ok); end
    n_checks++; if ({err_overflow, err_spurious} !== 2'b00) begin n_fail++; $display("FAIL mid_errors got %b exp 00", {err_overflow, err_spurious}); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_overflow();
    test_spurious();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
